// File: rtl/gray_encoder_if.sv
// Bus bundle for the Gray encoder. The driver side owns bin/in_valid and the
// encoder owns the combinational and registered results.
interface gray_encoder_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] bin;
  logic             in_valid;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_q;
  logic             out_valid;
  logic             step_err;

  modport master (
    output bin, in_valid,
    input  gray, gray_q, bin_q, out_valid, step_err
  );

  modport slave (
    input  bin, in_valid,
    output gray, gray_q, bin_q, out_valid, step_err
  );
endinterface

// File: rtl/gray_encoder.sv
// Binary-to-Gray encoder: a zero-latency combinational code plus a registered
// copy with a valid flag, for feeding synchronisers straight from a flop.
// step_err flags a +1 binary step whose Gray codes differ in other than one bit.
module gray_encoder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  gray_encoder_if.slave bus
);

  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] gray_q_r;
  logic [WIDTH-1:0] bin_q_r;
  logic             out_valid_r;
  logic             step_err_r;
  logic             history;
  logic [WIDTH-1:0] bin_inc;
  logic             is_step;
  logic             bad_step;

  // Gray code of the live input; the shift leaves the MSB unchanged
  always_comb begin
    gray = bus.bin ^ (bus.bin >> 1);
  end

  // Step classification: only a +1 (modulo wrap) after a prior capture is checked
  always_comb begin
    bin_inc  = bin_q_r + WIDTH'(1);
    is_step  = history && (bus.bin == bin_inc);
    bad_step = is_step && ($countones(gray ^ gray_q_r) != 1);
  end

  // Capture register; rst wins over in_valid, idle cycles hold the data
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q_r    <= '0;
      bin_q_r     <= '0;
      out_valid_r <= 1'b0;
      step_err_r  <= 1'b0;
      history     <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        gray_q_r   <= gray;
        bin_q_r    <= bus.bin;
        history    <= 1'b1;
        step_err_r <= bad_step;
      end
    end
  end

  assign bus.gray      = gray;
  assign bus.gray_q    = gray_q_r;
  assign bus.bin_q     = bin_q_r;
  assign bus.out_valid = out_valid_r;
  assign bus.step_err  = step_err_r;

endmodule

// File: tb/tb_gray_encoder.sv
// Directed bench for gray_encoder: combinational map, registered capture,
// step checking (with a forced corrupt gray_q), reset mid-stream and WIDTH=1.
module tb_gray_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  logic [3:0] gmap [16];

  always #5 clk = ~clk;

  gray_encoder_if #(.WIDTH(4)) bus ();
  gray_encoder_if #(.WIDTH(1)) bus1 ();

  gray_encoder #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  gray_encoder #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Apply inputs, take one rising edge, then settle 1 ns before sampling
  task automatic cyc(input logic v, input logic [3:0] b, input logic r);
    bus.in_valid = v;
    bus.bin      = b;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    gmap = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    bus.in_valid  = 1'b0;
    bus.bin       = '0;
    bus1.in_valid = 1'b0;
    bus1.bin      = '0;

    // 1: combinational sweep
    for (int i = 0; i < 16; i++) begin
      bus.bin = 4'(i);
      #10;
      check($sformatf("comb_%0d", i), 32'(bus.gray), 32'(gmap[i]));
    end

    // 2: reset dominates a valid input
    cyc(1'b1, 4'b1010, 1'b1);
    cyc(1'b1, 4'b1010, 1'b1);
    check("rst_gray_comb", 32'(bus.gray), 32'h F);
    check("rst_gray_q", 32'(bus.gray_q), 32'h0);
    check("rst_bin_q", 32'(bus.bin_q), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_step_err", 32'(bus.step_err), 32'h0);

    // 3: single capture then hold
    cyc(1'b1, 4'b0101, 1'b0);
    check("cap_gray_q", 32'(bus.gray_q), 32'h7);
    check("cap_bin_q", 32'(bus.bin_q), 32'h5);
    check("cap_out_valid", 32'(bus.out_valid), 32'h1);
    cyc(1'b0, 4'b1100, 1'b0);
    check("hold_gray_q", 32'(bus.gray_q), 32'h7);
    check("hold_bin_q", 32'(bus.bin_q), 32'h5);
    check("hold_out_valid", 32'(bus.out_valid), 32'h0);

    // 4: increment 0..15 and wrap to 0
    cyc(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 4'(i % 16), 1'b0);
      check($sformatf("inc_gray_q_%0d", i), 32'(bus.gray_q), 32'(gmap[i % 16]));
      check($sformatf("inc_step_err_%0d", i), 32'(bus.step_err), 32'h0);
    end

    // 5: legal steps, jump, hold, then a corrupted gray_q
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0011, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    check("s5_3to4", 32'(bus.step_err), 32'h0);
    cyc(1'b1, 4'b0110, 1'b0);
    check("s5_jump", 32'(bus.step_err), 32'h0);
    cyc(1'b1, 4'b0111, 1'b0);
    check("s5_6to7", 32'(bus.step_err), 32'h0);
    cyc(1'b1, 4'b0111, 1'b0);
    check("s5_hold", 32'(bus.step_err), 32'h0);
    cyc(1'b1, 4'b0011, 1'b0);
    check("s5_down", 32'(bus.step_err), 32'h0);
    force dut.gray_q_r = 4'b0000;
    cyc(1'b1, 4'b0100, 1'b0);
    release dut.gray_q_r;
    check("s5_corrupt", 32'(bus.step_err), 32'h1);
    check("s5_corrupt_bin_q", 32'(bus.bin_q), 32'h4);

    // 6: reset mid-stream; next valid is treated as first
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    check("s6_stream", 32'(bus.step_err), 32'h0);
    cyc(1'b0, 4'b0000, 1'b1);
    check("s6_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("s6_rst_gray_q", 32'(bus.gray_q), 32'h0);
    cyc(1'b1, 4'b0100, 1'b0);
    check("s6_out_valid", 32'(bus.out_valid), 32'h1);
    check("s6_step_err", 32'(bus.step_err), 32'h0);
    check("s6_gray_q", 32'(bus.gray_q), 32'h6);
    // 0001 is bin_q+1 after reset; a bad gray_q must not be judged on the first capture
    cyc(1'b0, 4'b0000, 1'b1);
    force dut.gray_q_r = 4'b1111;
    cyc(1'b1, 4'b0001, 1'b0);
    release dut.gray_q_r;
    check("s6_first_no_check", 32'(bus.step_err), 32'h0);
    check("s6_first_bin_q", 32'(bus.bin_q), 32'h1);

    // WIDTH=1: gray equals bin, 0->1->0 are both single-bit steps
    cyc(1'b0, 4'b0000, 1'b1);
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus1.bin = 1'(i % 2);
      #1;
      check($sformatf("w1_comb_%0d", i), 32'(bus1.gray), 32'(i % 2));
      cyc(1'b0, 4'b0000, 1'b0);
      check($sformatf("w1_gray_q_%0d", i), 32'(bus1.gray_q), 32'(i % 2));
      check($sformatf("w1_step_err_%0d", i), 32'(bus1.step_err), 32'h0);
    end
    bus1.in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard time bound so the bench can never hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
